rvv_backend_dispatch_opr_byte_type_seq: RTL

Sequential, parametrised byte-type generator for the RVV dispatch stage.
- Accepts one vector instruction descriptor per handshake.
- Walks that instruction's uops in order, emitting one registered byte-type bundle (vs1, vs2, vd) per uop per cycle through a valid/ready handshake.
- Each operand is classified against its own EEW and its own v0 mask slice.
- Sits between the uop splitter and the dispatch-to-PU/RT path. It lets dispatch pre-compute byte types without a wide combinational path.

---
 rtl/rvv_backend_dispatch_opr_byte_type_seq_pkg.sv | 64 ++++++
 rtl/rvv_backend_byte_type_classify.sv | 52 +++++
 rtl/rvv_backend_dispatch_opr_byte_type_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rvv_backend_dispatch_opr_byte_type_seq_pkg.sv
// Shared types for the sequential byte-type generator.
// Optional feature macro: RVV_BYTE_TYPE_EEW64_EN (EEW64 operands, 8:1 widening).
package rvv_backend_dispatch_opr_byte_type_seq_pkg;

    localparam int unsigned VLENB         = 16;
    localparam int unsigned VLEN          = VLENB * 8;
    localparam int unsigned UOP_MAX       = 8;
    localparam int unsigned VL_WIDTH      = $clog2(VLEN) + 1;
    localparam int unsigned VSTART_WIDTH  = $clog2(VLEN);
    localparam int unsigned UOP_IDX_WIDTH = $clog2(UOP_MAX);
    localparam int unsigned ELE_WIDTH     = VL_WIDTH + 1;
    localparam int unsigned VLENB_LOG2    = $clog2(VLENB);
    localparam int unsigned VLEN_LOG2     = $clog2(VLEN);

    // Codes above EEW64 are reserved and classified as EEW8.
    typedef enum logic [2:0] {
        EEW8  = 3'd0,
        EEW16 = 3'd1,
        EEW32 = 3'd2,
        EEW64 = 3'd3
    } EEW_e;

    typedef enum logic [1:0] {
        NOT_CHANGE    = 2'd0,
        BODY_ACTIVE   = 2'd1,
        BODY_INACTIVE = 2'd2,
        TAIL          = 2'd3
    } BYTE_TYPE_e;

    typedef struct packed {
        BYTE_TYPE_e [VLENB-1:0] vs1;
        BYTE_TYPE_e [VLENB-1:0] vs2;
        BYTE_TYPE_e [VLENB-1:0] vd;
    } UOP_OPN_BYTE_TYPE_t;

    typedef struct packed {
        EEW_e                     vs1_eew;
        EEW_e                     vs2_eew;
        EEW_e                     vd_eew;
        logic [VL_WIDTH-1:0]      vl;
        logic [VSTART_WIDTH-1:0]  vstart;
        logic                     vm;
        logic                     ignore_vta;
        logic                     ignore_vma;
        logic [UOP_IDX_WIDTH-1:0] uop_num;
        logic [VLEN-1:0]          v0;
    } BYTE_TYPE_DESC_t;

    // log2(EEW/8); EEW64 only counts when the wide feature is built in.
    function automatic logic [1:0] eew_shift(input EEW_e eew);
        logic [1:0] sh;
        sh = 2'd0;
        case (eew)
            EEW16:   sh = 2'd1;
            EEW32:   sh = 2'd2;
`ifdef RVV_BYTE_TYPE_EEW64_EN
            EEW64:   sh = 2'd3;
`endif
            default: sh = 2'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/rvv_backend_byte_type_classify.sv
// Combinational byte-type classification for one operand of one uop.
module rvv_backend_byte_type_classify
    import rvv_backend_dispatch_opr_byte_type_seq_pkg::*;
(
    input  EEW_e                    eew,
    input  logic [ELE_WIDTH-1:0]    win_lo,
    input  logic [ELE_WIDTH-1:0]    win_hi,
    input  logic [VL_WIDTH-1:0]     vl,
    input  logic [VSTART_WIDTH-1:0] vstart,
    input  logic                    vm,
    input  logic                    ignore_vta,
    input  logic                    ignore_vma,
    input  logic [VLEN-1:0]         v0,
    output BYTE_TYPE_e [VLENB-1:0]  byte_type
);

    logic [1:0]           shift_x;
    logic [ELE_WIDTH-1:0] blk_mask;
    logic [ELE_WIDTH-1:0] base;
    logic [ELE_WIDTH-1:0] ele [VLENB];
    logic [VLENB-1:0]     v0_bit;

    // Elements of this operand's register that hold the window start.
    assign shift_x  = eew_shift(eew);
    assign blk_mask = ~((ELE_WIDTH'(VLENB) >> shift_x) - ELE_WIDTH'(1));
    assign base     = win_lo & blk_mask;

    // Per-byte element index and first-match classification.
    always_comb begin
        for (int i = 0; i < VLENB; i++) begin
            ele[i]       = '0;
            v0_bit[i]    = 1'b0;
            byte_type[i] = NOT_CHANGE;
        end
        for (int i = 0; i < VLENB; i++) begin
            ele[i]    = base + (ELE_WIDTH'(i) >> shift_x);
            v0_bit[i] = (ele[i] < ELE_WIDTH'(VLEN)) ? v0[ele[i][VLEN_LOG2-1:0]] : 1'b0;
            if (ele[i] >= ELE_WIDTH'(vl)) begin
                byte_type[i] = ignore_vta ? BODY_ACTIVE : TAIL;
            end else if (ele[i] < ELE_WIDTH'(vstart)) begin
                byte_type[i] = NOT_CHANGE;
            end else if ((ele[i] < win_lo) || (ele[i] > win_hi)) begin
                byte_type[i] = BODY_INACTIVE;
            end else if (vm || ignore_vma || v0_bit[i]) begin
                byte_type[i] = BODY_ACTIVE;
            end else begin
                byte_type[i] = BODY_INACTIVE;
            end
        end
    end

endmodule

// File: rtl/rvv_backend_dispatch_opr_byte_type_seq.sv
// Sequential byte-type generator: one descriptor in, one registered
// vs1/vs2/vd byte-type bundle per uop out.
// Optional feature macro: RVV_BYTE_TYPE_EEW64_EN.
module rvv_backend_dispatch_opr_byte_type_seq
    import rvv_backend_dispatch_opr_byte_type_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  EEW_e                     in_vs1_eew,
    input  EEW_e                     in_vs2_eew,
    input  EEW_e                     in_vd_eew,
    input  logic [VL_WIDTH-1:0]      in_vl,
    input  logic [VSTART_WIDTH-1:0]  in_vstart,
    input  logic                     in_vm,
    input  logic                     in_ignore_vta,
    input  logic                     in_ignore_vma,
    input  logic [UOP_IDX_WIDTH-1:0] in_uop_num,
    input  logic [VLEN-1:0]          in_v0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [UOP_IDX_WIDTH-1:0] out_uop_index,
    output logic                     out_last,
    output UOP_OPN_BYTE_TYPE_t       out_byte_type
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e                   state_q, state_d;
    BYTE_TYPE_DESC_t          desc_q, desc_d, in_desc, src_desc;
    logic [UOP_IDX_WIDTH-1:0] src_uop, uop_d;
    logic                     last_d;
    UOP_OPN_BYTE_TYPE_t       bt_d;
    logic                     accept;
    logic [1:0]               sh_vs1, sh_vs2, sh_vd, shift_max;
    logic [ELE_WIDTH-1:0]     epu, win_lo, win_hi;
    BYTE_TYPE_e [VLENB-1:0]   vs1_bt, vs2_bt, vd_bt;

    // Pack the incoming descriptor.
    always_comb begin
        in_desc            = '0;
        in_desc.vs1_eew    = in_vs1_eew;
        in_desc.vs2_eew    = in_vs2_eew;
        in_desc.vd_eew     = in_vd_eew;
        in_desc.vl         = in_vl;
        in_desc.vstart     = in_vstart;
        in_desc.vm         = in_vm;
        in_desc.ignore_vta = in_ignore_vta;
        in_desc.ignore_vma = in_ignore_vma;
        in_desc.uop_num    = in_uop_num;
        in_desc.v0         = in_v0;
    end

    // Accepting on the last handoff keeps the output stream bubble-free.
    assign out_valid = (state_q == RUN);
    assign in_ready  = (state_q == IDLE) || (out_valid && out_last && out_ready);
    assign accept    = in_valid && in_ready;

    // A new instruction classifies straight from the inputs at uop 0.
    assign src_desc = accept ? in_desc : desc_q;
    assign src_uop  = accept ? '0 : out_uop_index + UOP_IDX_WIDTH'(1);

    assign sh_vs1 = eew_shift(src_desc.vs1_eew);
    assign sh_vs2 = eew_shift(src_desc.vs2_eew);
    assign sh_vd  = eew_shift(src_desc.vd_eew);

    // Widest operand sets the number of elements covered by one uop.
    always_comb begin
        shift_max = sh_vs1;
        if (sh_vs2 > shift_max) shift_max = sh_vs2;
        if (sh_vd > shift_max)  shift_max = sh_vd;
    end

    assign epu    = ELE_WIDTH'(VLENB) >> shift_max;
    assign win_lo = (ELE_WIDTH'(src_uop) << VLENB_LOG2) >> shift_max;
    assign win_hi = win_lo + epu - ELE_WIDTH'(1);

    rvv_backend_byte_type_classify u_cls_vs1 (
        .eew        (src_desc.vs1_eew),
        .win_lo     (win_lo),
        .win_hi     (win_hi),
        .vl         (src_desc.vl),
        .vstart     (src_desc.vstart),
        .vm         (src_desc.vm),
        .ignore_vta (src_desc.ignore_vta),
        .ignore_vma (src_desc.ignore_vma),
        .v0         (src_desc.v0),
        .byte_type  (vs1_bt)
    );

    rvv_backend_byte_type_classify u_cls_vs2 (
        .eew        (src_desc.vs2_eew),
        .win_lo     (win_lo),
        .win_hi     (win_hi),
        .vl         (src_desc.vl),
        .vstart     (src_desc.vstart),
        .vm         (src_desc.vm),
        .ignore_vta (src_desc.ignore_vta),
        .ignore_vma (src_desc.ignore_vma),
        .v0         (src_desc.v0),
        .byte_type  (vs2_bt)
    );

    rvv_backend_byte_type_classify u_cls_vd (
        .eew        (src_desc.vd_eew),
        .win_lo     (win_lo),
        .win_hi     (win_hi),
        .vl         (src_desc.vl),
        .vstart     (src_desc.vstart),
        .vm         (src_desc.vm),
        .ignore_vta (src_desc.ignore_vta),
        .ignore_vma (src_desc.ignore_vma),
        .v0         (src_desc.v0),
        .byte_type  (vd_bt)
    );

    // Next state, descriptor capture and output-register load.
    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        uop_d   = out_uop_index;
        last_d  = out_last;
        bt_d    = out_byte_type;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = RUN;
                        desc_d  = in_desc;
                    end
                end
                RUN: begin
                    if (out_ready && out_last) begin
                        if (in_valid) begin
                            desc_d = in_desc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            endcase
            if (accept || (out_valid && out_ready && !out_last)) begin
                uop_d    = src_uop;
                last_d   = (src_uop == src_desc.uop_num);
                bt_d.vs1 = vs1_bt;
                bt_d.vs2 = vs2_bt;
                bt_d.vd  = vd_bt;
            end
        end
    end

    // State, descriptor and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            desc_q        <= '0;
            out_uop_index <= '0;
            out_last      <= 1'b0;
            out_byte_type <= '0;
        end else begin
            state_q       <= state_d;
            desc_q        <= desc_d;
            out_uop_index <= uop_d;
            out_last      <= last_d;
            out_byte_type <= bt_d;
        end
    end

endmodule
